cpu_run_ctrl: RTL and testbench

- Run/step/breakpoint sequencer for the single-cycle CPU. It replaces the free-running divide-by-2 CPU clock.
- Generates cpu_clk from mem_clk, so every CPU cycle is exactly 2 mem_clk cycles. imem and dmem stay on mem_clk.
- cpu_clk runs continuously, advances one instruction per debounced key press, or freezes when the CPU PC matches a breakpoint address.
- Status outputs are intended for the LEDs and seven-segment displays on the board.

---
 rtl/cpu_run_ctrl.sv | 134 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step/breakpoint sequencer generating the CPU clock from mem_clk
module cpu_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 32
) (
    input  logic             mem_clk,
    input  logic             resetn,
    input  logic             run_sw,
    input  logic             step_btn_n,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    output logic             cpu_clk,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } state_t;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            run_meta, run_sync;
    logic            btn_meta, btn_sync;
    logic            btn_db;
    logic [DB_W-1:0] db_cnt;
    logic            db_hit;
    logic            step_pulse;

    state_t          state_q, state_n;
    logic            clk_q, clk_n;
    logic            skip_q, skip_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic            halted_q;

    always_ff @(posedge mem_clk) begin
        if (!resetn) begin
            run_meta <= 1'b0;
            run_sync <= 1'b0;
            btn_meta <= 1'b1;
            btn_sync <= 1'b1;
        end else begin
            run_meta <= run_sw;
            run_sync <= run_meta;
            btn_meta <= step_btn_n;
            btn_sync <= btn_meta;
        end
    end

    // The press is reported on the same edge the debounced level flips low.
    assign db_hit     = (btn_sync != btn_db) && (db_cnt == DB_LAST);
    assign step_pulse = db_hit && btn_db;

    always_ff @(posedge mem_clk) begin
        if (!resetn) begin
            btn_db <= 1'b1;
            db_cnt <= '0;
        end else if (btn_sync != btn_db) begin
            if (db_hit) begin
                btn_db <= btn_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    always_comb begin
        state_n = state_q;
        clk_n   = clk_q;
        skip_n  = skip_q;
        cnt_n   = cnt_q;
        if (clk_q) begin
            // Falling edge closes a CPU period.
            clk_n  = 1'b0;
            cnt_n  = cnt_q + CNT_W'(1);
            skip_n = 1'b0;
            if (state_q == ST_STEP) state_n = ST_STOP;
        end else begin
            case (state_q)
                ST_STOP: begin
                    if (step_pulse)    state_n = ST_STEP;
                    else if (run_sync) state_n = ST_RUN;
                end
                ST_RUN: begin
                    if (!run_sync) begin
                        state_n = ST_STOP;
                    end else if (bp_en && (pc == bp_addr) && !skip_q) begin
                        state_n = ST_BREAK;
                        skip_n  = 1'b1;
                    end else begin
                        clk_n = 1'b1;
                    end
                end
                ST_STEP: clk_n = 1'b1;
                ST_BREAK: begin
                    if (step_pulse)     state_n = ST_STEP;
                    else if (!run_sync) state_n = ST_STOP;
                end
                default: state_n = ST_STOP;
            endcase
        end
    end

    always_ff @(posedge mem_clk) begin
        if (!resetn) begin
            state_q  <= ST_STOP;
            clk_q    <= 1'b0;
            skip_q   <= 1'b0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            clk_q    <= clk_n;
            skip_q   <= skip_n;
            cnt_q    <= cnt_n;
            halted_q <= (state_n == ST_BREAK);
        end
    end

    assign cpu_clk     = clk_q;
    assign state       = state_q;
    assign halted      = halted_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench for cpu_run_ctrl with a behavioural reference model
module tb_cpu_run_ctrl;

    localparam int DEB = 4;

    logic        mem_clk = 1'b0;
    logic        resetn = 1'b0;
    logic        run_sw = 1'b0;
    logic        step_btn_n = 1'b1;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'h0;
    logic [31:0] pc = 32'h0;
    logic        cpu_clk;
    logic [1:0]  state;
    logic        halted;
    logic [31:0] cycle_count;

    int total = 0;
    int bad = 0;

    // reference model state
    int          m_state;
    bit          m_clk;
    int unsigned m_cnt;
    bit          m_skip;
    bit          run_q[$];
    bit          btn_q[$];
    bit          m_db;
    int          m_dbrun;
    bit          prev_clk = 1'b0;
    int          rises = 0;

    cpu_run_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(32)) dut (
        .mem_clk    (mem_clk),
        .resetn     (resetn),
        .run_sw     (run_sw),
        .step_btn_n (step_btn_n),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .cpu_clk    (cpu_clk),
        .state      (state),
        .halted     (halted),
        .cycle_count(cycle_count)
    );

    always #5 mem_clk = ~mem_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rn, input bit r, input bit b, input bit be,
                              input logic [31:0] ba, input logic [31:0] p);
        bit run_seen, btn_seen, press;
        if (!rn) begin
            m_state = 0; m_clk = 0; m_cnt = 0; m_skip = 0;
            run_q = '{1'b0, 1'b0};
            btn_q = '{1'b1, 1'b1};
            m_db = 1; m_dbrun = 0;
            return;
        end
        run_seen = run_q.pop_front(); run_q.push_back(r);
        btn_seen = btn_q.pop_front(); btn_q.push_back(b);
        press = 0;
        if (btn_seen != m_db) begin
            m_dbrun++;
            if (m_dbrun == DEB) begin
                m_db = btn_seen;
                m_dbrun = 0;
                press = (btn_seen == 0);
            end
        end else begin
            m_dbrun = 0;
        end
        if (m_clk) begin
            m_clk = 0; m_cnt++; m_skip = 0;
            if (m_state == 2) m_state = 0;
        end else begin
            case (m_state)
                0: if (press) m_state = 2; else if (run_seen) m_state = 1;
                1: begin
                    if (!run_seen) m_state = 0;
                    else if (be && p == ba && !m_skip) begin m_state = 3; m_skip = 1; end
                    else m_clk = 1;
                end
                2: m_clk = 1;
                default: if (press) m_state = 2; else if (!run_seen) m_state = 0;
            endcase
        end
    endtask

    task automatic tick();
        bit rn = resetn;
        bit r = run_sw;
        bit b = step_btn_n;
        bit be = bp_en;
        logic [31:0] ba = bp_addr;
        logic [31:0] p = pc;
        @(posedge mem_clk);
        model_edge(rn, r, b, be, ba, p);
        #1;
        chk("state", state, m_state);
        chk("cpu_clk", cpu_clk, m_clk);
        chk("halted", halted, m_state == 3);
        chk("cycle_count", cycle_count, m_cnt);
        if (cpu_clk && !prev_clk) begin
            pc = pc + 32'd4;
            rises++;
        end
        prev_clk = cpu_clk;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        ticks(2);
        resetn = 1'b1;
    endtask

    initial begin
        int n, hold;
        int unsigned c0;
        int r0;

        do_reset();
        chk("rst_state", state, 0);
        chk("rst_clk", cpu_clk, 0);
        chk("rst_cnt", cycle_count, 0);
        chk("rst_halted", halted, 0);

        // free run
        run_sw = 1'b1;
        n = 0;
        do begin tick(); n++; end while (state != 2'd1 && n < 20);
        chk("run_latency", n, 3);
        ticks(6);
        c0 = cycle_count; r0 = rises;
        ticks(20);
        chk("run_periods", cycle_count - c0, 10);
        chk("run_rises", rises - r0, 10);
        run_sw = 1'b0;
        ticks(6);
        chk("run_stop", state, 0);

        // clean press
        c0 = cycle_count; r0 = rises;
        step_btn_n = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!cpu_clk && n < 30);
        chk("step_latency", n, 7);
        tick();
        chk("step_width", cpu_clk, 0);
        ticks(2);
        step_btn_n = 1'b1;
        ticks(20);
        chk("step_rises", rises - r0, 1);
        chk("step_count", cycle_count - c0, 1);
        chk("step_stop", state, 0);

        // bouncy press
        c0 = cycle_count; r0 = rises;
        for (int i = 0; i < 6; i++) begin
            step_btn_n = (i % 2 == 1);
            ticks(2);
        end
        chk("bounce_early", rises - r0, 0);
        step_btn_n = 1'b0;
        ticks(20);
        chk("bounce_rises", rises - r0, 1);
        step_btn_n = 1'b1;
        ticks(20);
        chk("bounce_release", rises - r0, 1);
        chk("bounce_count", cycle_count - c0, 1);

        // breakpoint
        pc = 32'h0;
        do_reset();
        bp_en = 1'b1; bp_addr = 32'hC; run_sw = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!halted && n < 100);
        chk("bp_halt", halted, 1);
        chk("bp_pc", pc, 32'hC);
        chk("bp_clk", cpu_clk, 0);
        chk("bp_cnt", cycle_count, 3);
        ticks(10);
        chk("bp_hold", state, 3);
        run_sw = 1'b0;
        ticks(4);
        chk("bp_stop", state, 0);
        step_btn_n = 1'b0;
        n = 0;
        do begin tick(); n++; end while (cycle_count != 32'd4 && n < 30);
        chk("bpstep_pc", pc, 32'h10);
        chk("bpstep_cnt", cycle_count, 4);
        chk("bpstep_state", state, 0);
        step_btn_n = 1'b1;
        ticks(10);
        run_sw = 1'b1;
        ticks(6);
        chk("bp_resume", state, 1);

        // step and run arrive together in STOP
        bp_en = 1'b0;
        run_sw = 1'b0;
        ticks(8);
        chk("sim_pre", state, 0);
        c0 = cycle_count;
        step_btn_n = 1'b0;
        ticks(3);
        run_sw = 1'b1;
        ticks(2);
        tick();
        chk("sim_step", state, 2);
        ticks(2);
        chk("sim_cnt", cycle_count - c0, 1);
        chk("sim_stop", state, 0);
        tick();
        chk("sim_run", state, 1);
        step_btn_n = 1'b1;

        // reset while cpu_clk is high
        n = 0;
        do begin tick(); n++; end while (!cpu_clk && n < 10);
        chk("rstmid_pre", cpu_clk, 1);
        resetn = 1'b0;
        tick();
        chk("rstmid_clk", cpu_clk, 0);
        chk("rstmid_state", state, 0);
        chk("rstmid_cnt", cycle_count, 0);
        resetn = 1'b1;

        // randomized traffic against the model
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 40) == 0) run_sw = ~run_sw;
            if (hold == 0) begin
                step_btn_n = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 12);
            end
            hold--;
            if ($urandom_range(0, 60) == 0) begin
                bp_en = 1'($urandom_range(0, 1));
                bp_addr = pc + 32'd4 * $urandom_range(0, 3);
            end
            resetn = ($urandom_range(0, 500) != 0);
            tick();
        end
        resetn = 1'b1;
        ticks(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
